irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NSRC, default 8, meaning number of interrupt sources (legal 1..31).
REQ-002 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have sel  input  1  register access select.
REQ-005 SHALL have we  input  1  write enable; qualified by sel.
REQ-006 SHALL have addr  input  4  byte offset: 0x0 ENABLE, 0x4 PENDING, 0x8 TYPE, 0xC CLAIM.
REQ-007 SHALL have wdata  input  32  write data.
REQ-008 SHALL have rdata  output  32  combinational read data for addr; driven regardless of sel.
REQ-009 SHALL have irq_src  input  NSRC  interrupt sources; bit 0 connects to timer timeout_irq.
REQ-010 SHALL have irq_out  output  1  registered CPU interrupt request.
REQ-011 SHALL have irq_id  output  5  registered winning source index+1; 0 when none.

Function
REQ-012 SHALL hold per-source registers enable[i], type[i] (1 edge, 0 level), pending[i], src_q[i] (previous irq_src sample).
REQ-013 SHALL update src_q <= irq_src every cycle.
REQ-014 SHALL, for edge source, set pending[i] at the edge where irq_src[i]=1 and src_q[i]=0.
REQ-015 SHALL, for level source, set pending[i] at every edge where irq_src[i]=1.
REQ-016 SHALL latch pending regardless of enable[i]; enable masks only arbitration and irq_out.
REQ-017 SHALL clear pending[i] on write to PENDING with wdata[i]=1 (W1C); wdata[i]=0 leaves bit unchanged.
REQ-018 SHALL clear pending[k-1] on write to CLAIM with wdata[4:0]=k, 1<=k<=NSRC; k=0 or k>NSRC ignored.
REQ-019 SHALL give set priority over clear when set and clear hit the same bit in the same cycle.
REQ-020 SHALL compute active = pending & enable; winner = lowest-index set bit of active.
REQ-021 SHALL register irq_out <= |active and irq_id <= winner+1 (0 if active empty) each cycle: one cycle after pending/enable change.
REQ-022 SHALL give source-rise-to-irq_out latency of 2 edges: pending set at edge N, irq_out high after edge N+1.
REQ-023 SHALL read ENABLE/TYPE/PENDING as {zero-extended NSRC bits}; CLAIM reads {27'd0, irq_id}; undefined offsets read 0.
REQ-024 SHALL write ENABLE and TYPE fully from wdata[NSRC-1:0]; bits above NSRC ignored.
REQ-025 SHALL not alter pending when TYPE or ENABLE is written.
REQ-026 SHALL have no side effect on reads.

Reset
REQ-027 SHALL, when reset=1 at a clock edge, clear enable, type, pending, src_q, irq_out, irq_id to 0; reset overrides any same-cycle write or source event.
REQ-028 SHALL treat a source high at reset release as an edge on the first post-reset edge (src_q=0).

Structure
REQ-029 SHALL place register offsets (ENABLE/PENDING/TYPE/CLAIM) and ID width constant in shared package irq_ctrl_pkg.
REQ-030 SHALL implement lowest-index-first arbitration in one sub-module irq_prio_enc (input NSRC vector, output valid + index).

Verification
REQ-031 SHALL cover: ENABLE=0x01, TYPE=0, irq_src[0] held high -> PENDING=0x01 after 1 edge, irq_out=1 and CLAIM=1 after 2 edges; W1C 0x01 while high -> PENDING re-sets next edge.
REQ-032 SHALL cover: TYPE=0x04, ENABLE=0x04, 1-cycle pulse on irq_src[2] -> PENDING=0x04 stays after pulse ends; write CLAIM=3 -> PENDING=0, irq_out=0 one edge later.
REQ-033 SHALL cover: ENABLE=0xFF, sources 5 and 3 pending -> irq_id=4; clear bit 3 -> irq_id=6.
REQ-034 SHALL cover: ENABLE=0x00, edge on src 1 -> PENDING=0x02, irq_out=0; write ENABLE=0x02 -> irq_out=1 next edge.
REQ-035 SHALL cover: edge source rises in same cycle as W1C of its bit -> PENDING bit remains 1.
REQ-036 SHALL cover: reset asserted with PENDING=0xFF, irq_out=1 -> all registers 0, irq_out=0, irq_id=0 after that edge.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register map, id width and
// a small helper that turns an encoder result into the CPU-visible id.
package irq_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int ID_W   = 5;

    localparam logic [3:0] ADDR_ENABLE  = 4'h0;
    localparam logic [3:0] ADDR_PENDING = 4'h4;
    localparam logic [3:0] ADDR_TYPE    = 4'h8;
    localparam logic [3:0] ADDR_CLAIM   = 4'hC;

    // Encoded interrupt id: 0 means no request, otherwise source index + 1.
    function automatic logic [ID_W-1:0] make_id(input logic valid,
                                                input logic [ID_W-1:0] index);
        logic [ID_W-1:0] id;
        id = '0;
        if (valid) begin
            id = index + 1'b1;
        end
        return id;
    endfunction

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the index of
// the lowest-numbered one, which is the source that wins arbitration.
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int N = 8
)
(
    input  logic [N-1:0]    req,
    output logic            valid,
    output logic [ID_W-1:0] index
);

    // Scan from the top down so the lowest set bit is the last one to write index.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                index = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches edge- or level-type sources into a pending
// register, masks them with an enable register and presents the lowest
// active source to the CPU as a registered request plus id.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NSRC = 8
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic              we,
    input  logic [3:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    input  logic [NSRC-1:0]   irq_src,
    output logic              irq_out,
    output logic [ID_W-1:0]   irq_id
);

    logic [NSRC-1:0] enable_q;
    logic [NSRC-1:0] type_q;
    logic [NSRC-1:0] pending_q;
    logic [NSRC-1:0] src_q;

    logic            wr_en;
    logic [ID_W-1:0] claim_k;
    logic [NSRC-1:0] set_vec;
    logic [NSRC-1:0] w1c_vec;
    logic [NSRC-1:0] claim_vec;
    logic [NSRC-1:0] pending_d;
    logic [NSRC-1:0] active;
    logic            win_valid;
    logic [ID_W-1:0] win_index;

    logic            unused_wdata;

    assign wr_en        = sel & we;
    assign claim_k      = wdata[ID_W-1:0];
    assign active       = pending_q & enable_q;
    assign unused_wdata = ^wdata[DATA_W-1:NSRC];

    // Source events: level sources request whenever high, edge sources only
    // when the previous sample was low (src_q is zero after reset, so a source
    // already high at release counts as a fresh edge).
    always_comb begin
        set_vec = irq_src & ~(type_q & src_q);
    end

    // Write-one-to-clear mask from a PENDING write.
    always_comb begin
        w1c_vec = '0;
        if (wr_en && (addr == ADDR_PENDING)) begin
            w1c_vec = wdata[NSRC-1:0];
        end
    end

    // Claim clears the single source whose id was written; id 0 and ids beyond
    // the number of sources match no bit and are therefore ignored.
    always_comb begin
        claim_vec = '0;
        if (wr_en && (addr == ADDR_CLAIM)) begin
            for (int i = 0; i < NSRC; i++) begin
                if (claim_k == ID_W'(i + 1)) begin
                    claim_vec[i] = 1'b1;
                end
            end
        end
    end

    // Next pending value: a new event on a bit wins over a same-cycle clear.
    always_comb begin
        pending_d = set_vec | (pending_q & ~(w1c_vec | claim_vec));
    end

    irq_prio_enc #(
        .N     (NSRC)
    ) u_prio_enc (
        .req   (active),
        .valid (win_valid),
        .index (win_index)
    );

    // Register state and CPU outputs; reset overrides writes and source events.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q  <= '0;
            type_q    <= '0;
            pending_q <= '0;
            src_q     <= '0;
            irq_out   <= 1'b0;
            irq_id    <= '0;
        end else begin
            src_q     <= irq_src;
            pending_q <= pending_d;
            if (wr_en && (addr == ADDR_ENABLE)) begin
                enable_q <= wdata[NSRC-1:0];
            end
            if (wr_en && (addr == ADDR_TYPE)) begin
                type_q <= wdata[NSRC-1:0];
            end
            irq_out <= win_valid;
            irq_id  <= make_id(win_valid, win_index);
        end
    end

    // Read mux is purely combinational and independent of sel.
    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_ENABLE:  rdata[NSRC-1:0] = enable_q;
            ADDR_PENDING: rdata[NSRC-1:0] = pending_q;
            ADDR_TYPE:    rdata[NSRC-1:0] = type_q;
            ADDR_CLAIM:   rdata[ID_W-1:0] = irq_id;
            default:      rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with hand-derived expectations,
// followed by a randomized run checked against a behavioural model.
module tb_irq_ctrl;

    localparam int NSRC = 8;

    logic        clk;
    logic        reset;
    logic        sel;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  irq_src;
    logic        irq_out;
    logic [4:0]  irq_id;

    int vectors;
    int miscompares;

    // Behavioural model state.
    logic [7:0] m_en;
    logic [7:0] m_ty;
    logic [7:0] m_pend;
    logic [7:0] m_srcq;
    logic       m_irq;
    logic [4:0] m_id;

    irq_ctrl #(
        .NSRC    (NSRC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sel     (sel),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq_src (irq_src),
        .irq_out (irq_out),
        .irq_id  (irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of what the registers read back as at a given offset.
    function automatic logic [31:0] ref_rdata(input logic [3:0] a);
        logic [31:0] r;
        r = 32'd0;
        if (a == 4'h0) r = {24'd0, m_en};
        else if (a == 4'h4) r = {24'd0, m_pend};
        else if (a == 4'h8) r = {24'd0, m_ty};
        else if (a == 4'hC) r = {27'd0, m_id};
        return r;
    endfunction

    // One clock edge: the model computes the next state from the inputs being
    // driven, the edge happens, then the model commits.
    task automatic applyStimulus();
        logic [7:0] n_en, n_ty, n_pend, act, clr;
        logic       n_irq;
        logic [4:0] n_id;
        logic       wr;
        int         k;
        if (reset) begin
            n_en = 0; n_ty = 0; n_pend = 0; n_irq = 0; n_id = 0;
        end else begin
            wr  = sel && we;
            act = m_pend & m_en;
            n_irq = (act != 0);
            n_id  = (act == 0) ? 5'd0 : 5'($clog2(act & (~act + 8'd1)) + 1);
            clr = 0;
            if (wr && addr == 4'h4) clr = wdata[7:0];
            k = int'(wdata[4:0]);
            if (wr && addr == 4'hC && k >= 1 && k <= NSRC) clr = clr | 8'(1 << (k - 1));
            for (int i = 0; i < NSRC; i++) begin
                if (irq_src[i] && (!m_ty[i] || !m_srcq[i])) n_pend[i] = 1'b1;
                else if (clr[i]) n_pend[i] = 1'b0;
                else n_pend[i] = m_pend[i];
            end
            n_en = (wr && addr == 4'h0) ? wdata[7:0] : m_en;
            n_ty = (wr && addr == 4'h8) ? wdata[7:0] : m_ty;
        end
        @(posedge clk);
        #1;
        m_srcq = reset ? 8'd0 : irq_src;
        m_en = n_en; m_ty = n_ty; m_pend = n_pend; m_irq = n_irq; m_id = n_id;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        applyStimulus();
        sel = 1'b0; we = 1'b0; wdata = 32'd0;
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic do_reset();
        reset = 1'b1; irq_src = 8'd0; sel = 1'b0; we = 1'b0;
        applyStimulus();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        vectors++;
        if (irq_out !== 1'b0 || irq_id !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: irq_out=%0b irq_id=%0d, required 0/0", irq_out, irq_id);
        end
        for (int a = 0; a < 16; a += 4) begin
            read_reg(4'(a), d);
            vectors++;
            if (d !== 32'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_reg_%0h: read 0x%08h, required 0", a, d);
            end
        end
    endtask

    task automatic test_level();
        logic [31:0] d;
        do_reset();
        bus_write(4'h0, 32'h01);
        bus_write(4'h8, 32'h00);
        irq_src = 8'h01;
        applyStimulus();
        read_reg(4'h4, d);
        vectors++;
        if (d !== 32'h01 || irq_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL level_pending: PENDING=0x%0h irq_out=%0b, required 0x1/0", d, irq_out);
        end
        applyStimulus();
        read_reg(4'hC, d);
        vectors++;
        if (irq_out !== 1'b1 || d !== 32'd1) begin
            miscompares++;
            $display("[TB] FAIL level_irq: irq_out=%0b CLAIM=%0d, required 1/1", irq_out, d);
        end
        bus_write(4'h4, 32'h01);
        read_reg(4'h4, d);
        vectors++;
        if (d !== 32'h01) begin
            miscompares++;
            $display("[TB] FAIL level_w1c_reset: PENDING=0x%0h, required 0x1", d);
        end
        irq_src = 8'h00;
    endtask

    task automatic test_edge_claim();
        logic [31:0] d;
        do_reset();
        bus_write(4'h8, 32'h04);
        bus_write(4'h0, 32'h04);
        irq_src = 8'h04;
        applyStimulus();
        irq_src = 8'h00;
        applyStimulus();
        read_reg(4'h4, d);
        vectors++;
        if (d !== 32'h04 || irq_out !== 1'b1 || irq_id !== 5'd3) begin
            miscompares++;
            $display("[TB] FAIL edge_latch: PENDING=0x%0h irq_out=%0b id=%0d, required 0x4/1/3", d, irq_out, irq_id);
        end
        bus_write(4'hC, 32'd3);
        read_reg(4'h4, d);
        applyStimulus();
        vectors++;
        if (d !== 32'h00 || irq_out !== 1'b0 || irq_id !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL edge_claim: PENDING=0x%0h irq_out=%0b id=%0d, required 0/0/0", d, irq_out, irq_id);
        end
    endtask

    task automatic test_priority();
        do_reset();
        bus_write(4'h0, 32'hFF);
        irq_src = 8'h28;
        applyStimulus();
        irq_src = 8'h00;
        applyStimulus();
        vectors++;
        if (irq_id !== 5'd4) begin
            miscompares++;
            $display("[TB] FAIL prio_first: irq_id=%0d, required 4", irq_id);
        end
        bus_write(4'h4, 32'h08);
        applyStimulus();
        vectors++;
        if (irq_id !== 5'd6 || irq_out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL prio_second: irq_id=%0d irq_out=%0b, required 6/1", irq_id, irq_out);
        end
    endtask

    task automatic test_enable_mask();
        logic [31:0] d;
        do_reset();
        bus_write(4'h8, 32'h02);
        irq_src = 8'h02;
        applyStimulus();
        irq_src = 8'h00;
        applyStimulus();
        read_reg(4'h4, d);
        vectors++;
        if (d !== 32'h02 || irq_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mask_pending: PENDING=0x%0h irq_out=%0b, required 0x2/0", d, irq_out);
        end
        bus_write(4'h0, 32'h02);
        vectors++;
        if (irq_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mask_write_edge: irq_out=%0b, required 0", irq_out);
        end
        applyStimulus();
        vectors++;
        if (irq_out !== 1'b1 || irq_id !== 5'd2) begin
            miscompares++;
            $display("[TB] FAIL mask_enable: irq_out=%0b id=%0d, required 1/2", irq_out, irq_id);
        end
    endtask

    task automatic test_set_vs_clear();
        logic [31:0] d;
        do_reset();
        bus_write(4'h8, 32'h01);
        irq_src = 8'h01;
        bus_write(4'h4, 32'h01);
        irq_src = 8'h00;
        read_reg(4'h4, d);
        vectors++;
        if (d !== 32'h01) begin
            miscompares++;
            $display("[TB] FAIL set_beats_clear: PENDING=0x%0h, required 0x1", d);
        end
    endtask

    task automatic test_reset_override();
        logic [31:0] d;
        do_reset();
        bus_write(4'h0, 32'hFF);
        irq_src = 8'hFF;
        applyStimulus();
        applyStimulus();
        read_reg(4'h4, d);
        vectors++;
        if (d !== 32'hFF || irq_out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rst_setup: PENDING=0x%0h irq_out=%0b, required 0xff/1", d, irq_out);
        end
        reset = 1'b1; sel = 1'b1; we = 1'b1; addr = 4'h8; wdata = 32'hFF;
        applyStimulus();
        sel = 1'b0; we = 1'b0;
        vectors++;
        if (irq_out !== 1'b0 || irq_id !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL rst_outputs: irq_out=%0b id=%0d, required 0/0", irq_out, irq_id);
        end
        for (int a = 0; a < 12; a += 4) begin
            read_reg(4'(a), d);
            vectors++;
            if (d !== 32'd0) begin
                miscompares++;
                $display("[TB] FAIL rst_reg_%0h: read 0x%08h, required 0", a, d);
            end
        end
        reset = 1'b0;
        irq_src = 8'h00;
    endtask

    task automatic test_random();
        logic [3:0]  addrs [6];
        logic [31:0] exp_r;
        addrs = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h2, 4'hE};
        do_reset();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            sel   = $urandom_range(0, 1) == 1;
            we    = $urandom_range(0, 2) != 0;
            addr  = addrs[$urandom_range(0, 5)];
            wdata = (addr == 4'hC) ? 32'($urandom_range(0, 10)) : $urandom;
            if ($urandom_range(0, 3) == 0) irq_src = 8'($urandom);
            applyStimulus();
            sel = 1'b0; we = 1'b0; reset = 1'b0;
            vectors++;
            if (irq_out !== m_irq || irq_id !== m_id) begin
                miscompares++;
                $display("[TB] FAIL rand_out[%0d]: irq_out=%0b id=%0d, required %0b/%0d", n, irq_out, irq_id, m_irq, m_id);
            end
            addr = addrs[$urandom_range(0, 5)];
            #1;
            exp_r = ref_rdata(addr);
            vectors++;
            if (rdata !== exp_r) begin
                miscompares++;
                $display("[TB] FAIL rand_rdata[%0d] addr=%0h: read 0x%08h, required 0x%08h", n, addr, rdata, exp_r);
            end
        end
        irq_src = 8'h00;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b1; sel = 1'b0; we = 1'b0; addr = 4'h0; wdata = 32'd0; irq_src = 8'd0;
        m_en = 0; m_ty = 0; m_pend = 0; m_srcq = 0; m_irq = 0; m_id = 0;
        test_reset();
        test_level();
        test_edge_claim();
        test_priority();
        test_enable_mask();
        test_set_vs_clear();
        test_reset_override();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
